axi_eth_tx_arbiter: RTL and testbench

//  Shares the single Ethernet TX framer port among N packet sources (ARP TX, UDP TX, ...).

---
 rtl/axi_udp_pkg.sv | 32 +++
 rtl/axi_rr_arbiter.sv | 38 +++
 rtl/axi_eth_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_axi_eth_tx_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_udp_pkg.sv
// Shared types for the Ethernet TX arbitration path: FSM states, register bundle, helpers.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package axi_udp_pkg;

  // Upper bound on the number of sources one arbiter instance can serve.
  localparam int MAX_ETH_SRC = 8;
  localparam int SRC_IDX_W   = $clog2(MAX_ETH_SRC);

  typedef logic [SRC_IDX_W-1:0] src_idx_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_STREAM = 2'd2
  } arb_state_t;

  // Every piece of arbiter state lives in this one register bundle.
  typedef struct packed {
    arb_state_t  state;
    logic        req;
    src_idx_t    grant;
    src_idx_t    last_grant;
    logic [15:0] byte_cnt;
  } reg_t;

  // Frame byte counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/axi_rr_arbiter.sv
// Round-robin picker: first requesting index strictly after last_idx, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the winner.
module axi_rr_arbiter
  import axi_udp_pkg::*;
#(
  parameter int N_SRC = 2
) (
  input  logic [N_SRC-1:0] req,
  input  src_idx_t         last_idx,
  output src_idx_t         winner,
  output logic             valid
);

  logic     hi_vld;
  src_idx_t hi_idx;
  src_idx_t lo_idx;

  // Split the search into "above last_idx" and "wrap-around" halves; descending
  // scans leave the lowest matching index in each half.
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i] && (src_idx_t'(i) > last_idx)) begin
        hi_vld = 1'b1;
        hi_idx = src_idx_t'(i);
      end
      if (req[i] && (src_idx_t'(i) <= last_idx)) begin
        lo_idx = src_idx_t'(i);
      end
    end
    valid  = |req;
    winner = hi_vld ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/axi_eth_tx_arbiter.sv
// Shares one Ethernet TX framer port among N_SRC sources, round-robin, one whole frame per grant.
// Latency: eth_req one cycle after src_req; eth_ack->src_ack and data/ready paths are combinational.
// Backpressure: eth_axis_tready routed straight to the granted source; all other sources see tready=0.
module axi_eth_tx_arbiter
  import axi_udp_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter bit DEBUG = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SRC-1:0]    src_req,
  output logic [N_SRC-1:0]    src_ack,
  input  logic [N_SRC*48-1:0] src_dst_mac,
  input  logic [N_SRC*48-1:0] src_src_mac,
  input  logic [N_SRC*16-1:0] src_ethertype,
  input  logic [N_SRC*8-1:0]  src_axis_tdata,
  input  logic [N_SRC-1:0]    src_axis_tlast,
  input  logic [N_SRC-1:0]    src_axis_tvalid,
  output logic [N_SRC-1:0]    src_axis_tready,
  output logic                eth_req,
  input  logic                eth_ack,
  output logic [47:0]         eth_dst_mac,
  output logic [47:0]         eth_src_mac,
  output logic [15:0]         eth_ethertype,
  output logic [7:0]          eth_axis_tdata,
  output logic                eth_axis_tlast,
  output logic                eth_axis_tvalid,
  input  logic                eth_axis_tready,
  output logic                busy,
  output logic [2:0]          grant_idx
);

  // last_grant starts at the top index so source 0 wins the first arbitration.
  localparam reg_t RES_reg = '{
    state:      S_IDLE,
    req:        1'b0,
    grant:      '0,
    last_grant: src_idx_t'(N_SRC - 1),
    byte_cnt:   16'd0
  };

  reg_t r_q;
  reg_t r_d;

  logic     arb_vld;
  src_idx_t arb_idx;

  logic       mux_tvalid;
  logic       mux_tlast;
  logic [7:0] mux_tdata;
  logic       in_stream;
  logic       in_req;
  logic       beat;

  axi_rr_arbiter #(
    .N_SRC(N_SRC)
  ) u_rr (
    .req     (src_req),
    .last_idx(r_q.last_grant),
    .winner  (arb_idx),
    .valid   (arb_vld)
  );

  assign in_stream = (r_q.state == S_STREAM);
  assign in_req    = (r_q.state == S_REQ);
  assign beat      = in_stream && mux_tvalid && eth_axis_tready;

  // State register; reset aborts any frame in flight without closing it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RES_reg;
    end else begin
      r_q <= r_d;
    end
  end

  // Header and payload selected by the current grant (headers held stable for the whole frame).
  always_comb begin
    eth_dst_mac   = '0;
    eth_src_mac   = '0;
    eth_ethertype = '0;
    mux_tdata     = '0;
    mux_tlast     = 1'b0;
    mux_tvalid    = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_q.grant == src_idx_t'(i)) begin
        eth_dst_mac   = src_dst_mac[i*48 +: 48];
        eth_src_mac   = src_src_mac[i*48 +: 48];
        eth_ethertype = src_ethertype[i*16 +: 16];
        mux_tdata     = src_axis_tdata[i*8 +: 8];
        mux_tlast     = src_axis_tlast[i];
        mux_tvalid    = src_axis_tvalid[i];
      end
    end
  end

  // Next-state logic: grant in IDLE, handshake in REQ, count beats until tlast in STREAM.
  always_comb begin
    r_d = r_q;
    unique case (r_q.state)
      S_IDLE: begin
        if (arb_vld) begin
          r_d.grant = arb_idx;
          r_d.req   = 1'b1;
          r_d.state = S_REQ;
        end
      end
      S_REQ: begin
        if (eth_ack) begin
          r_d.req      = 1'b0;
          r_d.byte_cnt = 16'd0;
          r_d.state    = S_STREAM;
        end
      end
      S_STREAM: begin
        if (beat) begin
          r_d.byte_cnt = sat_inc16(r_q.byte_cnt);
          if (mux_tlast) begin
            r_d.last_grant = r_q.grant;
            r_d.state      = S_IDLE;
          end
        end
      end
      default: begin
        r_d = RES_reg;
      end
    endcase
  end

  // Per-source handshake fan-out: only the granted source sees ack or ready.
  always_comb begin
    src_ack         = '0;
    src_axis_tready = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_q.grant == src_idx_t'(i)) begin
        src_ack[i]         = in_req && eth_ack;
        src_axis_tready[i] = in_stream && eth_axis_tready;
      end
    end
  end

  assign eth_axis_tdata  = mux_tdata;
  assign eth_axis_tlast  = in_stream && mux_tlast;
  assign eth_axis_tvalid = in_stream && mux_tvalid;
  assign eth_req         = r_q.req;
  assign busy            = (r_q.state != S_IDLE);
  assign grant_idx       = 3'(r_q.grant);

  if (DEBUG) begin : g_debug
    // Frame-end sanity: every completed frame came from a real source and carried data.
    always_ff @(posedge clk) begin
      if (!rst && beat && mux_tlast) begin
        assert (int'(r_q.grant) < N_SRC && r_d.byte_cnt != 16'd0);
      end
    end
  end

endmodule

// File: tb/tb_axi_eth_tx_arbiter.sv
module tb_axi_eth_tx_arbiter;

  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   src_req;
  logic [N-1:0]   src_ack;
  logic [N*48-1:0] src_dst_mac;
  logic [N*48-1:0] src_src_mac;
  logic [N*16-1:0] src_ethertype;
  logic [N*8-1:0] src_axis_tdata;
  logic [N-1:0]   src_axis_tlast;
  logic [N-1:0]   src_axis_tvalid;
  logic [N-1:0]   src_axis_tready;
  logic           eth_req;
  logic           eth_ack;
  logic [47:0]    eth_dst_mac;
  logic [47:0]    eth_src_mac;
  logic [15:0]    eth_ethertype;
  logic [7:0]     eth_axis_tdata;
  logic           eth_axis_tlast;
  logic           eth_axis_tvalid;
  logic           eth_axis_tready;
  logic           busy;
  logic [2:0]     grant_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_eth_tx_arbiter #(.N_SRC(N), .DEBUG(1'b0)) dut (
    .clk(clk), .rst(rst),
    .src_req(src_req), .src_ack(src_ack),
    .src_dst_mac(src_dst_mac), .src_src_mac(src_src_mac), .src_ethertype(src_ethertype),
    .src_axis_tdata(src_axis_tdata), .src_axis_tlast(src_axis_tlast),
    .src_axis_tvalid(src_axis_tvalid), .src_axis_tready(src_axis_tready),
    .eth_req(eth_req), .eth_ack(eth_ack),
    .eth_dst_mac(eth_dst_mac), .eth_src_mac(eth_src_mac), .eth_ethertype(eth_ethertype),
    .eth_axis_tdata(eth_axis_tdata), .eth_axis_tlast(eth_axis_tlast),
    .eth_axis_tvalid(eth_axis_tvalid), .eth_axis_tready(eth_axis_tready),
    .busy(busy), .grant_idx(grant_idx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    src_req = '0; src_axis_tvalid = '0; src_axis_tlast = '0; src_axis_tdata = '0;
    eth_ack = 1'b0; eth_axis_tready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Drives one frame from source src (already requesting) and records what the DUT did.
  task automatic do_frame(input int src, input int len, input int ack_delay, input bit toggle_rdy,
                          input bit keep_req, output int wait_cyc, output int got_grant,
                          output logic [15:0] etype, output int ack_cnt, output int stray,
                          output int beats, output int order_errs, output int leaks,
                          output int last_pos, output bit timeout);
    int k;
    int cyc;
    logic [N-1:0] own;
    own = N'(1 << src);
    wait_cyc = 0; got_grant = -1; etype = '0; ack_cnt = 0; stray = 0; beats = 0;
    order_errs = 0; leaks = 0; last_pos = 0; timeout = 1'b0;
    while (eth_req !== 1'b1 && wait_cyc < 20) begin
      tick();
      wait_cyc++;
    end
    if (eth_req !== 1'b1) begin
      timeout = 1'b1;
      return;
    end
    got_grant = int'(grant_idx);
    etype = eth_ethertype;
    for (int d = 0; d < ack_delay; d++) begin
      if (src_ack !== '0) stray++;
      tick();
    end
    eth_ack = 1'b1;
    #1;
    if (src_ack === own) ack_cnt++;
    else stray++;
    tick();
    eth_ack = 1'b0;
    if (!keep_req) src_req[src] = 1'b0;
    k = 0;
    cyc = 0;
    while (k < len && cyc < 8 * len + 20) begin
      src_axis_tvalid[src] = 1'b1;
      src_axis_tdata[src*8 +: 8] = 8'((src << 7) + k);
      src_axis_tlast[src] = (k == len - 1);
      eth_axis_tready = toggle_rdy ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (src_ack !== '0) stray++;
      if ((src_axis_tready & ~own) !== '0 || src_axis_tready[src] !== eth_axis_tready) leaks++;
      if (eth_axis_tvalid === 1'b1 && eth_axis_tready === 1'b1) begin
        beats++;
        if (eth_axis_tdata !== 8'((src << 7) + k)) order_errs++;
        if (eth_axis_tlast === 1'b1) last_pos = beats;
        k++;
      end
      tick();
      cyc++;
    end
    if (k < len) timeout = 1'b1;
    src_axis_tvalid[src] = 1'b0;
    src_axis_tlast[src] = 1'b0;
    eth_axis_tready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    eth_ack = 1'b1; eth_axis_tready = 1'b1; src_axis_tvalid = '1;
    #1;
    checks++; if (eth_req !== 1'b0) begin errors++; $display("FAIL reset_eth_req got=%b exp=0", eth_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (src_ack !== 2'b00) begin errors++; $display("FAIL reset_src_ack got=%b exp=00", src_ack); end
    checks++; if (src_axis_tready !== 2'b00) begin errors++; $display("FAIL reset_tready got=%b exp=00", src_axis_tready); end
    checks++; if (eth_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", eth_axis_tvalid); end
    checks++; if (grant_idx !== 3'd0) begin errors++; $display("FAIL reset_grant got=%0d exp=0", grant_idx); end
    eth_ack = 1'b0; eth_axis_tready = 1'b0; src_axis_tvalid = '0;
  endtask

  task automatic test_single_arp();
    int w, g, a, s, b, o, l, lp;
    logic [15:0] et;
    bit to;
    apply_reset();
    src_req[0] = 1'b1;
    do_frame(0, 28, 2, 1'b0, 1'b0, w, g, et, a, s, b, o, l, lp, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL arp_timeout got=%b exp=0", to); end
    checks++; if (w != 1) begin errors++; $display("FAIL arp_req_latency got=%0d exp=1", w); end
    checks++; if (g != 0) begin errors++; $display("FAIL arp_grant got=%0d exp=0", g); end
    checks++; if (et !== 16'h0806) begin errors++; $display("FAIL arp_ethertype got=%h exp=0806", et); end
    checks++; if (a != 1 || s != 0) begin errors++; $display("FAIL arp_ack good=%0d stray=%0d exp=1,0", a, s); end
    checks++; if (b != 28) begin errors++; $display("FAIL arp_beats got=%0d exp=28", b); end
    checks++; if (lp != 28) begin errors++; $display("FAIL arp_tlast_pos got=%0d exp=28", lp); end
    checks++; if (o != 0) begin errors++; $display("FAIL arp_order errs=%0d exp=0", o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arp_idle_after got=%b exp=0", busy); end
    tick();
    checks++; if (eth_req !== 1'b0) begin errors++; $display("FAIL arp_no_rereq got=%b exp=0", eth_req); end
  endtask

  task automatic test_simultaneous();
    int w, g, a, s, b, o, l, lp;
    logic [15:0] et;
    bit to;
    apply_reset();
    src_req = 2'b11;
    do_frame(0, 6, 1, 1'b0, 1'b0, w, g, et, a, s, b, o, l, lp, to);
    checks++; if (g != 0 || to) begin errors++; $display("FAIL sim_first_grant got=%0d exp=0", g); end
    checks++; if (a != 1 || s != 0) begin errors++; $display("FAIL sim_first_ack good=%0d stray=%0d exp=1,0", a, s); end
    do_frame(1, 6, 1, 1'b0, 1'b0, w, g, et, a, s, b, o, l, lp, to);
    checks++; if (g != 1 || to) begin errors++; $display("FAIL sim_second_grant got=%0d exp=1", g); end
    checks++; if (w != 1) begin errors++; $display("FAIL sim_idle_gap got=%0d exp=1", w); end
    checks++; if (et !== 16'h0800) begin errors++; $display("FAIL sim_second_ethertype got=%h exp=0800", et); end
    checks++; if (b != 6 || o != 0) begin errors++; $display("FAIL sim_second_data beats=%0d errs=%0d exp=6,0", b, o); end
  endtask

  task automatic test_alternate();
    int w, g, a, s, b, o, l, lp;
    logic [15:0] et;
    bit to;
    apply_reset();
    src_req = 2'b11;
    for (int f = 0; f < 4; f++) begin
      do_frame(f % 2, 4, 0, 1'b0, 1'b1, w, g, et, a, s, b, o, l, lp, to);
      checks++; if (g != f % 2 || to) begin errors++; $display("FAIL alt_grant_%0d got=%0d exp=%0d", f, g, f % 2); end
      checks++; if (a != 1 || b != 4) begin errors++; $display("FAIL alt_frame_%0d ack=%0d beats=%0d exp=1,4", f, a, b); end
    end
    src_req = 2'b00;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL alt_release got=%b exp=0", busy); end
  endtask

  task automatic test_tready_toggle();
    int w, g, a, s, b, o, l, lp;
    logic [15:0] et;
    bit to;
    apply_reset();
    src_axis_tvalid[1] = 1'b1;
    src_axis_tdata[15:8] = 8'hEE;
    src_req[0] = 1'b1;
    do_frame(0, 60, 1, 1'b1, 1'b0, w, g, et, a, s, b, o, l, lp, to);
    src_axis_tvalid[1] = 1'b0;
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL tog_timeout got=%b exp=0", to); end
    checks++; if (b != 60) begin errors++; $display("FAIL tog_beats got=%0d exp=60", b); end
    checks++; if (o != 0) begin errors++; $display("FAIL tog_order errs=%0d exp=0", o); end
    checks++; if (l != 0) begin errors++; $display("FAIL tog_tready_route leaks=%0d exp=0", l); end
    checks++; if (lp != 60) begin errors++; $display("FAIL tog_tlast_pos got=%0d exp=60", lp); end
  endtask

  task automatic test_rst_mid();
    int w, g, a, s, b, o, l, lp;
    logic [15:0] et;
    bit to;
    apply_reset();
    src_req[0] = 1'b1;
    w = 0;
    while (eth_req !== 1'b1 && w < 20) begin tick(); w++; end
    checks++; if (eth_req !== 1'b1) begin errors++; $display("FAIL rstmid_req_timeout got=%b exp=1", eth_req); end
    eth_ack = 1'b1;
    tick();
    eth_ack = 1'b0;
    src_req[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      src_axis_tvalid[0] = 1'b1;
      src_axis_tdata[7:0] = 8'(k);
      eth_axis_tready = 1'b1;
      tick();
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_streaming got=%b exp=1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (eth_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid got=%b exp=0", eth_axis_tvalid); end
    checks++; if (eth_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle req=%b busy=%b exp=0,0", eth_req, busy); end
    checks++; if (src_axis_tready !== 2'b00) begin errors++; $display("FAIL rstmid_tready got=%b exp=00", src_axis_tready); end
    src_axis_tvalid = '0;
    eth_axis_tready = 1'b0;
    src_req[1] = 1'b1;
    do_frame(1, 5, 1, 1'b0, 1'b0, w, g, et, a, s, b, o, l, lp, to);
    checks++; if (g != 1 || to) begin errors++; $display("FAIL rstmid_regrant got=%0d exp=1", g); end
    checks++; if (a != 1 || b != 5 || o != 0) begin errors++; $display("FAIL rstmid_frame ack=%0d beats=%0d errs=%0d exp=1,5,0", a, b, o); end
  endtask

  task automatic test_spurious_ack();
    int w, g, a, s, b, o, l, lp;
    logic [15:0] et;
    bit to;
    apply_reset();
    eth_ack = 1'b1;
    #1;
    checks++; if (src_ack !== 2'b00) begin errors++; $display("FAIL spur_ack_idle got=%b exp=00", src_ack); end
    tick();
    eth_ack = 1'b0;
    checks++; if (busy !== 1'b0 || eth_req !== 1'b0) begin errors++; $display("FAIL spur_state busy=%b req=%b exp=0,0", busy, eth_req); end
    src_req[1] = 1'b1;
    do_frame(1, 8, 1, 1'b0, 1'b0, w, g, et, a, s, b, o, l, lp, to);
    checks++; if (g != 1 || to) begin errors++; $display("FAIL spur_grant got=%0d exp=1", g); end
    checks++; if (a != 1 || s != 0) begin errors++; $display("FAIL spur_real_ack good=%0d stray=%0d exp=1,0", a, s); end
    checks++; if (b != 8 || lp != 8) begin errors++; $display("FAIL spur_frame beats=%0d tlast=%0d exp=8,8", b, lp); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    src_dst_mac   = {48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455};
    src_src_mac   = {48'h0200_0000_0001, 48'h0200_0000_0000};
    src_ethertype = {16'h0800, 16'h0806};
    test_reset();
    test_single_arp();
    test_simultaneous();
    test_alternate();
    test_tready_toggle();
    test_rst_mid();
    test_spurious_ack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
